// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command-frame controller.
//   - State encoding for the frame FSM (3 bits, S_IDLE..S_HOLD).
//   - Default sync marker and length-field width.
package uart_cmd_pkg;

  localparam int unsigned LEN_W = 4;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte idle counter.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   clear_i : synchronous clear, has priority over counting
//   en_i    : count enable
//   tc_o    : high while enabled and the count sits at TIMEOUT_CLKS-1
module uart_byte_timer #(
  parameter int unsigned TIMEOUT_CLKS = 104170
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CntW-1:0] TcVal = CntW'(TIMEOUT_CLKS - 1);

  logic [CntW-1:0] count_q, count_d;

  assign tc_o = en_i && (count_q == TcVal);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame/command controller behind the UART receiver.
// Frame: SYNC CMD LEN payload[LEN] CHK, CHK = XOR of CMD, LEN and payload.
//   i_Clock, i_Rst_L       : clock, asynchronous active-low reset
//   i_Rx_DV, i_Rx_Byte     : received-byte strobe and data
//   o_Cmd_Valid, i_Cmd_Ready : command handshake
//   o_Cmd, o_Len, o_Payload  : validated command fields (payload byte i at [8i+7:8i])
//   o_Err_Chk/Len/Tmo/Ovr  : one-cycle error pulses
//   o_Busy                 : FSM not idle
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 8,
  parameter int unsigned TIMEOUT_CLKS = 104170,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_Rx_DV,
  input  logic [7:0]           i_Rx_Byte,
  output logic                 o_Cmd_Valid,
  input  logic                 i_Cmd_Ready,
  output logic [7:0]           o_Cmd,
  output logic [LEN_W-1:0]     o_Len,
  output logic [8*MAX_LEN-1:0] o_Payload,
  output logic                 o_Err_Chk,
  output logic                 o_Err_Len,
  output logic                 o_Err_Tmo,
  output logic                 o_Err_Ovr,
  output logic                 o_Busy
);

  // Compared against the full 8-bit LEN byte so values >= 16 are rejected too.
  localparam logic [7:0] MaxLenB = 8'(MAX_LEN);

  logic [2:0]           state_q, state_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [8*MAX_LEN-1:0] payload_q, payload_d;
  logic [LEN_W-1:0]     idx_q, idx_d;
  logic [LEN_W-1:0]     idx_inc;
  logic [7:0]           chk_q, chk_d;
  logic                 err_chk_q, err_chk_d;
  logic                 err_len_q, err_len_d;
  logic                 err_tmo_q, err_tmo_d;
  logic                 err_ovr_q, err_ovr_d;

  logic tmr_en;
  logic tmr_tc;

  // Counting only inside a frame, before the command is handed over.
  assign tmr_en = (state_q == S_CMD) || (state_q == S_LEN) ||
                  (state_q == S_DATA) || (state_q == S_CHK);

  uart_byte_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timer (
    .clk_i  (i_Clock),
    .rst_ni (i_Rst_L),
    .clear_i(i_Rx_DV || !tmr_en),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  assign idx_inc = idx_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    chk_d     = chk_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (i_Rx_DV) begin
          cmd_d     = i_Rx_Byte;
          chk_d     = i_Rx_Byte;
          len_d     = '0;
          payload_d = '0;
          idx_d     = '0;
          state_d   = S_LEN;
        end
      end
      S_LEN: begin
        if (i_Rx_DV) begin
          chk_d = chk_q ^ i_Rx_Byte;
          if (i_Rx_Byte == 8'd0) begin
            state_d = S_CHK;
          end else if (i_Rx_Byte <= MaxLenB) begin
            len_d   = i_Rx_Byte[LEN_W-1:0];
            state_d = S_DATA;
          end else begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (i_Rx_DV) begin
          for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (idx_q == LEN_W'(i)) begin
              payload_d[8*i +: 8] = i_Rx_Byte;
            end
          end
          chk_d = chk_q ^ i_Rx_Byte;
          idx_d = idx_inc;
          if (idx_inc == len_q) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == chk_q) begin
            state_d = S_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        // Any byte arriving while a command is held is dropped, even on the handshake cycle.
        if (i_Rx_DV) begin
          err_ovr_d = 1'b1;
        end
        if (i_Cmd_Ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A byte on the terminal-count cycle wins over the timeout.
    if (tmr_tc && !i_Rx_DV) begin
      err_tmo_d = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      chk_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      chk_q     <= chk_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  assign o_Cmd_Valid = (state_q == S_HOLD);
  assign o_Busy      = (state_q != S_IDLE);
  assign o_Cmd       = cmd_q;
  assign o_Len       = len_q;
  assign o_Payload   = payload_q;
  assign o_Err_Chk   = err_chk_q;
  assign o_Err_Len   = err_len_q;
  assign o_Err_Tmo   = err_tmo_q;
  assign o_Err_Ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected events, a negedge monitor
// pops and compares on every valid rise and every error pulse.
module tb_uart_cmd_ctrl;

  localparam int unsigned MaxLen  = 8;
  localparam int unsigned TmoClks = 50;

  localparam int KCmd = 0;
  localparam int KChk = 1;
  localparam int KLen = 2;
  localparam int KTmo = 3;
  localparam int KOvr = 4;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        dv      = 1'b0;
  logic        ready   = 1'b0;
  logic [7:0]  rx_byte = 8'h00;

  logic              o_cmd_valid;
  logic [7:0]        o_cmd;
  logic [3:0]        o_len;
  logic [8*MaxLen-1:0] o_payload;
  logic              o_err_chk, o_err_len, o_err_tmo, o_err_ovr, o_busy;

  typedef struct {
    int          kind;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] pl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        valid_prev;
  logic [75:0] held;

  uart_cmd_ctrl #(
    .MAX_LEN     (MaxLen),
    .TIMEOUT_CLKS(TmoClks),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .i_Clock    (clk),
    .i_Rst_L    (rst_n),
    .i_Rx_DV    (dv),
    .i_Rx_Byte  (rx_byte),
    .o_Cmd_Valid(o_cmd_valid),
    .i_Cmd_Ready(ready),
    .o_Cmd      (o_cmd),
    .o_Len      (o_len),
    .o_Payload  (o_payload),
    .o_Err_Chk  (o_err_chk),
    .o_Err_Len  (o_err_len),
    .o_Err_Tmo  (o_err_tmo),
    .o_Err_Ovr  (o_err_ovr),
    .o_Busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_evt(input int kind);
    exp_t e;
    e.kind = kind;
    e.cmd  = '0;
    e.len  = '0;
    e.pl   = '0;
    sb.push_back(e);
  endtask

  task automatic expect_cmd(input logic [7:0] c, input logic [3:0] l, input logic [63:0] p);
    exp_t e;
    e.kind = KCmd;
    e.cmd  = c;
    e.len  = l;
    e.pl   = p;
    sb.push_back(e);
  endtask

  task automatic pop_check(input int kind);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected no event", kind);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind: got kind %0d expected kind %0d", kind, e.kind);
      end else if (kind == KCmd &&
                   (o_cmd !== e.cmd || o_len !== e.len || o_payload !== e.pl)) begin
        errors++;
        $display("FAIL cmd_fields: got cmd=%0h len=%0h pl=%0h expected cmd=%0h len=%0h pl=%0h",
                 o_cmd, o_len, o_payload, e.cmd, e.len, e.pl);
      end
    end
  endtask

  task automatic stable_check();
    checks++;
    if ({o_cmd, o_len, o_payload} !== held) begin
      errors++;
      $display("FAIL hold_stable: got %0h expected %0h", {o_cmd, o_len, o_payload}, held);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      valid_prev <= 1'b0;
    end else begin
      if (o_cmd_valid && !valid_prev) pop_check(KCmd);
      if (o_cmd_valid && valid_prev)  stable_check();
      if (o_err_chk) pop_check(KChk);
      if (o_err_len) pop_check(KLen);
      if (o_err_tmo) pop_check(KTmo);
      if (o_err_ovr) pop_check(KOvr);
      valid_prev <= o_cmd_valid;
      held       <= {o_cmd, o_len, o_payload};
    end
  end

  // One DV strobe, sampled by exactly one rising edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1;
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv      = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic release_cmd();
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    check("release_valid_low", 64'(o_cmd_valid), 64'd0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check(name, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("rst_flags", 64'({o_cmd_valid, o_busy, o_err_chk, o_err_len, o_err_tmo, o_err_ovr}),
          64'd0);
    check("rst_cmd_len", 64'({o_cmd, o_len}), 64'd0);
    check("rst_payload", o_payload, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: good frame, valid held until ready
    expect_cmd(8'h10, 4'd2, 64'h2211);
    send_frame('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
    check("t1_latency", 64'(o_cmd_valid), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("t1_still_valid", 64'(o_cmd_valid), 64'd1);
    release_cmd();
    drain("t1_drain");

    // 2: checksum error
    expect_evt(KChk);
    send_frame('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20});
    drain("t2_drain");
    check("t2_busy", 64'({o_busy, o_cmd_valid}), 64'd0);

    // 3: junk then bad length
    expect_evt(KLen);
    send_frame('{8'h00, 8'hFF, 8'hA5, 8'h40, 8'h09});
    drain("t3_drain");
    check("t3_busy", 64'(o_busy), 64'd0);

    // 4: timeout then a zero-length frame
    expect_evt(KTmo);
    send_frame('{8'hA5, 8'h10});
    drain("t4_tmo_drain");
    check("t4_busy", 64'(o_busy), 64'd0);
    expect_cmd(8'h33, 4'd0, 64'h0);
    send_frame('{8'hA5, 8'h33, 8'h00, 8'h33});
    check("t4_valid", 64'(o_cmd_valid), 64'd1);
    release_cmd();
    drain("t4_drain");

    // 5: overruns while holding, last one on the handshake cycle
    expect_cmd(8'h10, 4'd2, 64'h2211);
    send_frame('{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21});
    expect_evt(KOvr);
    expect_evt(KOvr);
    expect_evt(KOvr);
    send_byte(8'h01);
    send_byte(8'hA5);
    check("t5_cmd", 64'(o_cmd), 64'h10);
    check("t5_len", 64'(o_len), 64'd2);
    check("t5_payload", o_payload, 64'h2211);
    @(posedge clk);
    #1;
    dv      = 1'b1;
    rx_byte = 8'h03;
    ready   = 1'b1;
    @(posedge clk);
    #1;
    dv      = 1'b0;
    ready   = 1'b0;
    check("t5_release", 64'(o_cmd_valid), 64'd0);
    drain("t5_drain");

    // 6: async reset mid-payload, then recovery
    send_frame('{8'hA5, 8'h10, 8'h04, 8'h11});
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_flags",
          64'({o_cmd_valid, o_busy, o_err_chk, o_err_len, o_err_tmo, o_err_ovr}), 64'd0);
    check("t6_rst_fields", 64'({o_cmd, o_len}), 64'd0);
    check("t6_rst_payload", o_payload, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_cmd(8'h20, 4'd1, 64'h7E);
    send_frame('{8'hA5, 8'h20, 8'h01, 8'h7E, 8'h5F});
    check("t6_valid", 64'(o_cmd_valid), 64'd1);
    release_cmd();
    drain("t6_drain");

    // 6b: byte lands on the terminal-count cycle, no timeout
    send_frame('{8'hA5, 8'h10});
    repeat (48) @(posedge clk);
    expect_cmd(8'h10, 4'd0, 64'h0);
    send_byte(8'h00);
    check("t6_no_tmo", 64'(o_err_tmo), 64'd0);
    send_byte(8'h10);
    check("t6_tc_valid", 64'(o_cmd_valid), 64'd1);
    release_cmd();
    drain("t6_tc_drain");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
